alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. Executes single-cycle ALU operations (ADD, SUB, AND, ORR, EOR, BIC) plus an iterative shift-add multiply and an optional restoring unsigned divide. Uses valid/ready handshakes on input and output and registers every result. Sits in the execute stage behind the hazard unit, which stalls on `in_ready` low.

## Interface
- `WIDTH`, 32, operand/result width in bits (>= 4).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  WIDTH  operands, sampled on accept.
- `ALUControl`  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 BIC (a & ~b), 110 MUL, 111 UDIV.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts result.
- `Result`  out  WIDTH  registered result.
- `Flags`  out  4  registered {N, Z, C, V}.

## Operation
- Accept occurs when `in_valid & in_ready`. `a`, `b` and `ALUControl` are captured on that edge.
- FSM states:
  - IDLE: accept a single-cycle op -> DONE; accept MUL/UDIV -> ITER.
  - ITER: 5-bit-wide counter (clog2(WIDTH)) runs WIDTH steps -> DONE.
  - DONE: leaves on `out_ready` -> IDLE.
- ADD/SUB: sum = a + (SUB ? ~b : b) + SUB, computed at WIDTH+1 bits.
  - C = bit WIDTH of sum. For SUB, C = 1 means no borrow.
  - V = ~(a[MSB] ^ b[MSB] ^ SUB) & (a[MSB] ^ sum[MSB]).
- Logic ops: C = 0, V = 0.
- MUL: low WIDTH bits of the unsigned product; one shift-add step per cycle. C = 0, V = 0.
- UDIV: quotient; one restoring step per cycle. C = 0, V = 0.
  - Divisor 0: Result = all ones, V = 1. Still takes WIDTH cycles.
- All ops: N = Result[MSB]; Z = (Result == 0).
- `Result`/`Flags` stay stable throughout DONE and hold their last value in IDLE and ITER.
- `out_valid` is high only in DONE.
- `in_ready` is low in ITER and DONE. There is no overlap between operations.
- Reset (asynchronous, at any time including mid-ITER or in DONE):
  - state -> IDLE, `out_valid` = 0, `Result` = 0, `Flags` = 0000, counter = 0.
  - Any in-flight operation is discarded.
  - `in_ready` = 1 while in IDLE after reset.

## Timing
- Single-cycle ops: accept on edge k; `out_valid` goes high after edge k.
- MUL/UDIV: accept on edge k; ITER covers edges k+1 .. k+WIDTH-1; `out_valid` goes high after edge k+WIDTH (latency WIDTH cycles).
- Output handshake on edge m (`out_valid & out_ready`): `out_valid` falls and `in_ready` rises after edge m. The next accept is possible on edge m+1.
- Throughput for single-cycle ops with `out_ready` held high is one op per 2 cycles.
- `in_valid` asserted while `in_ready` is low is ignored; the requester must hold it.

## Configuration
- `ALU_SEQ_DIV_EN` defined: UDIV is built as specified above.
- Not defined: no divider logic is built. ALUControl 111 is treated as a single-cycle op with Result = 0 and Flags = 0100.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, Flags 1001, `out_valid` one cycle after accept.
- SUB 5 - 5 -> Result 0, Flags 0110. SUB 3 - 5 -> Result 0xFFFFFFFE, Flags 1000.
- MUL 0x00010000 * 0x00010000 -> Result 0, Flags 0100, `out_valid` exactly 32 cycles after accept, `in_ready` low throughout. MUL 1234 * 5678 -> 7006652.
- BIC 0xFF, 0x0F with `out_ready` low for 10 cycles -> 0x000000F0 held stable, `in_ready` low; `out_ready` high -> `in_ready` high on the next cycle.
- Reset pulsed 10 cycles into a MUL -> `out_valid` 0 immediately and the MUL result is never presented. After release, ADD 2 + 3 -> 5, Flags 0000.
- With `ALU_SEQ_DIV_EN`: UDIV 100 / 7 -> 14 after 32 cycles; UDIV 1 / 0 -> 0xFFFFFFFF, Flags 1001. Without it: op 111 -> 0, Flags 0100, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and optional restoring UDIV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op 111 is a single-cycle op returning 0.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W1 = WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_EOR  = 3'b100;
    localparam logic [2:0] OP_BIC  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_UDIV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] opa, opa_nx;
    logic [WIDTH-1:0] opb, opb_nx;
    logic [WIDTH-1:0] result_nx;
    logic [3:0]       flags_nx;
    logic             in_ready_nx;
    logic             out_valid_nx;

    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opa;
    logic [WIDTH-1:0] step_opb;
    logic [WIDTH-1:0] step_res;
    logic             step_v;
    logic             start_iter;

`ifdef ALU_SEQ_DIV_EN
    logic             is_div, is_div_nx;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             div_ge;
`endif

    // Single-cycle result and carry/overflow from the live operands
    always_comb begin
        sub     = (ALUControl == OP_SUB);
        sum     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + W1'(sub);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:          alu_res = a & b;
            OP_ORR:          alu_res = a | b;
            OP_EOR:          alu_res = a ^ b;
            OP_BIC:          alu_res = a & ~b;
            OP_MUL, OP_UDIV: alu_res = '0;
            default:         alu_res = '0;
        endcase
    end

    // One iteration step: shift-add multiply, or restoring divide when enabled
    always_comb begin
        step_acc = acc + (opb[0] ? opa : '0);
        step_opa = opa << 1;
        step_opb = opb >> 1;
        step_res = step_acc;
        step_v   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        rem_sh  = {acc, opa[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, opb};
        div_ge  = (rem_sh >= {1'b0, opb});
        if (is_div) begin
            step_acc = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            step_opa = {opa[WIDTH-2:0], div_ge};
            step_opb = opb;
            step_res = step_opa;
            step_v   = (opb == '0);
        end
`endif
    end

`ifdef ALU_SEQ_DIV_EN
    assign start_iter = (ALUControl == OP_MUL) || (ALUControl == OP_UDIV);
`else
    assign start_iter = (ALUControl == OP_MUL);
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        opa_nx    = opa;
        opb_nx    = opb;
        result_nx = Result;
        flags_nx  = Flags;
`ifdef ALU_SEQ_DIV_EN
        is_div_nx = is_div;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (start_iter) begin
                        state_nx = S_ITER;
                        cnt_nx   = '0;
                        acc_nx   = '0;
                        opa_nx   = a;
                        opb_nx   = b;
`ifdef ALU_SEQ_DIV_EN
                        is_div_nx = (ALUControl == OP_UDIV);
`endif
                    end else begin
                        state_nx  = S_DONE;
                        result_nx = alu_res;
                        flags_nx  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                    end
                end
            end
            S_ITER: begin
                cnt_nx = cnt + CW'(1);
                acc_nx = step_acc;
                opa_nx = step_opa;
                opb_nx = step_opb;
                if (cnt == LAST) begin
                    state_nx  = S_DONE;
                    cnt_nx    = '0;
                    result_nx = step_res;
                    flags_nx  = {step_res[WIDTH-1], (step_res == '0), 1'b0, step_v};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        in_ready_nx  = (state_nx == S_IDLE);
        out_valid_nx = (state_nx == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            Result    <= '0;
            Flags     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            is_div    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            acc       <= acc_nx;
            opa       <= opa_nx;
            opb       <= opb_nx;
            Result    <= result_nx;
            Flags     <= flags_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
`ifdef ALU_SEQ_DIV_EN
            is_div    <= is_div_nx;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised + directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 32;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    ALUControl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;
    logic [3:0]    Flags;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {result, N, Z, C, V} from plain integer arithmetic
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic [63:0] wide;
        longint      sr;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                wide = 64'(x) + 64'(y);
                r    = wide[31:0];
                c    = wide[32];
                sr   = longint'($signed(x)) + longint'($signed(y));
                v    = (sr != longint'($signed(r)));
            end
            3'd1: begin
                r  = x - y;
                c  = (x >= y);
                sr = longint'($signed(x)) - longint'($signed(y));
                v  = (sr != longint'($signed(r)));
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x & ~y;
            3'd6: begin
                wide = 64'(x) * 64'(y);
                r    = wide[31:0];
            end
            default: begin
                if (DIV_EN) begin
                    if (y == 0) begin
                        r = 32'hFFFF_FFFF;
                        v = 1'b1;
                    end else begin
                        r = x / y;
                    end
                end
            end
        endcase
        return {r, r[31], (r == 0), c, v};
    endfunction

    // Issue one op, check latency/busy, hold the result for 'hold' cycles, then release it
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [35:0] exp;
        int          n;
        int          lat_exp;
        logic        rdy_bad;
        string       pfx;
        pfx     = $sformatf("op%0d(%0h,%0h)", op, x, y);
        exp     = model(op, x, y);
        lat_exp = (op == 3'd6 || (DIV_EN && op == 3'd7)) ? int'(W) : 0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({pfx, ".in_ready_idle"}, 64'(in_ready), 64'(1));
        a = x;
        b = y;
        ALUControl = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        n = 0;
        rdy_bad = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({pfx, ".latency"}, 64'(n), 64'(lat_exp));
        check({pfx, ".busy_ready"}, 64'(rdy_bad | in_ready), 64'(0));
        check({pfx, ".result"}, 64'(Result), 64'(exp[35:4]));
        check({pfx, ".flags"}, 64'(Flags), 64'(exp[3:0]));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            check({pfx, ".hold"}, {26'd0, out_valid, in_ready, Flags, Result}, {26'd0, 2'b10, exp[3:0], exp[35:4]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({pfx, ".release"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5};
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 5)];
            1:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        ALUControl = '0;
        #3;
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.result", 64'(Result), 64'(0));
        check("reset.flags", 64'(Flags), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(3'd1, 32'd5, 32'd5, 0);
        do_op(3'd1, 32'd3, 32'd5, 1);
        do_op(3'd6, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(3'd6, 32'd1234, 32'd5678, 2);
        do_op(3'd5, 32'hFF, 32'h0F, 10);
        do_op(3'd7, 32'd100, 32'd7, 0);
        do_op(3'd7, 32'd1, 32'd0, 0);

        // Reset in the middle of a MUL discards it
        a = 32'd1234;
        b = 32'd5678;
        ALUControl = 3'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        check("midrst.in_ready", 64'(in_ready), 64'(1));
        check("midrst.result", 64'(Result), 64'(0));
        check("midrst.flags", 64'(Flags), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst.discard", 64'(seen), 64'(0));
        do_op(3'd0, 32'd2, 32'd3, 0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
